// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and constants for the word-to-byte memory sequencer
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RESP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam int             BYTES_PER_WORD = 4;
  localparam int             CNT_W          = 3;
  localparam logic [CNT_W-1:0] LAST_RD_CNT  = 3'd4;
  localparam logic [CNT_W-1:0] LAST_WR_CNT  = 3'd3;

endpackage

// File: rtl/mem_word_sequencer.sv
// rtl/mem_word_sequencer.sv - splits 32-bit word requests into four byte accesses on the external memory
// Optional end-of-program halt support is built when MEMSEQ_HALT_EN is defined.
module mem_word_sequencer
  import mem_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             halt,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] mar,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  input  logic             kraj
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-3:0] r_base_hi;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_rsp_valid;
  logic             r_halt;

  logic             w_rd_strobe;
  logic             w_wr_strobe;
  logic [7:0]       w_wr_lane;
  logic [7:0]       w_mem_byte;
  logic             w_halt_next;

`ifdef MEMSEQ_HALT_EN
  assign w_halt_next = r_halt | kraj;
  logic w_unused_bits;
  assign w_unused_bits = ^req_addr[1:0];
`else
  assign w_halt_next = 1'b0;
  logic w_unused_bits;
  assign w_unused_bits = ^{req_addr[1:0], kraj};
`endif

  // Memory-side strobes depend only on registered state, never on req_*.
  assign w_rd_strobe = (r_state == READ) && (r_cnt < LAST_RD_CNT);
  assign w_wr_strobe = (r_state == WRITE);
  assign w_mem_byte  = 8'(memdata);

  always_comb begin
    w_wr_lane = r_wdata[7:0];
    case (r_cnt[1:0])
      2'd1:    w_wr_lane = r_wdata[15:8];
      2'd2:    w_wr_lane = r_wdata[23:16];
      2'd3:    w_wr_lane = r_wdata[31:24];
      default: w_wr_lane = r_wdata[7:0];
    endcase
  end

  assign memread   = w_rd_strobe;
  assign memwrite  = w_wr_strobe;
  assign mar       = (w_rd_strobe || w_wr_strobe) ? {r_base_hi, r_cnt[1:0]} : '0;
  assign writedata = w_wr_strobe ? WIDTH'(w_wr_lane) : '0;
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign halt      = r_halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_base_hi   <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      r_halt <= w_halt_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_base_hi <= req_addr[WIDTH-1:2];
            r_wdata   <= req_wdata;
            r_cnt     <= '0;
            r_state   <= req_write ? WRITE : READ;
          end
        end
        READ: begin
          // Byte k arrives one cycle after it was issued, i.e. while r_cnt == k+1.
          case (r_cnt)
            3'd1:    r_rdata[7:0]   <= w_mem_byte;
            3'd2:    r_rdata[15:8]  <= w_mem_byte;
            3'd3:    r_rdata[23:16] <= w_mem_byte;
            3'd4:    r_rdata[31:24] <= w_mem_byte;
            default: ;
          endcase
          if (r_cnt == LAST_RD_CNT) r_state <= RESP;
          else                      r_cnt   <= r_cnt + 3'd1;
        end
        WRITE: begin
          if (r_cnt == LAST_WR_CNT) r_state <= RESP;
          else                      r_cnt   <= r_cnt + 3'd1;
        end
        RESP: begin
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_halt_next ? HALTED : IDLE;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_sequencer.sv
// tb/tb_mem_word_sequencer.sv - self-checking bench for mem_word_sequencer with a byte memory model
module tb_mem_word_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        halt;
  logic        memread;
  logic        memwrite;
  logic [7:0]  mar;
  logic [7:0]  writedata;
  logic [7:0]  memdata;
  logic        kraj = 1'b0;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic        load = 1'b0;
  logic [7:0]  q_mar[$];
  logic [7:0]  q_wd[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_word_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .halt(halt), .memread(memread), .memwrite(memwrite), .mar(mar),
    .writedata(writedata), .memdata(memdata), .kraj(kraj)
  );

  // Byte memory: read data appears one clock after memread.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else begin
      if (memwrite) mem[mar] <= writedata;
      if (memread)  memdata  <= mem[mar];
    end
  end

  always @(negedge clk) begin
    if (memread || memwrite) q_mar.push_back(mar);
    if (memwrite)            q_wd.push_back(writedata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] addr);
    logic [7:0] b;
    b = {addr[7:2], 2'b00};
    return {ref_mem[b+8'd3], ref_mem[b+8'd2], ref_mem[b+8'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] pack_q(input logic [7:0] q[$]);
    if (q.size() != 4) return 32'hxxxxxxxx;
    return {q[3], q[2], q[1], q[0]};
  endfunction

  task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output int lat);
    logic [31:0] held;
    q_mar.delete();
    q_wd.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = n; break; end
    end
    rd = rsp_rdata;
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
      @(posedge clk); #1;
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, held);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic expect_seq(input string tag, input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    logic [7:0] b;
    b = {addr[7:2], 2'b00};
    check({tag, "_mar"}, pack_q(q_mar), {b + 8'd3, b + 8'd2, b + 8'd1, b});
    if (wr) check({tag, "_wdata"}, pack_q(q_wd), wd);
    else    check({tag, "_nowrite"}, q_wd.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        wr;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}   = 32'h20020005;
    {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]} = 32'hFF000000;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;

    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_memread",   {31'b0, memread}, 32'd0);
    check("rst_memwrite",  {31'b0, memwrite}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_halt",      {31'b0, halt}, 32'd0);
    check("rst_mar",       {24'b0, mar}, 32'd0);
    check("rst_writedata", {24'b0, writedata}, 32'd0);
    check("rst_rdata",     rsp_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_txn(1'b0, 8'h04, 32'h0, 0, rd, lat);
    check("rd04_data", rd, 32'h20020005);
    check("rd04_lat", 32'(lat), 32'd6);
    expect_seq("rd04", 1'b0, 8'h04, 32'h0);

    do_txn(1'b1, 8'h10, 32'hDEADBEEF, 0, rd, lat);
    {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} = 32'hDEADBEEF;
    check("wr10_lat", 32'(lat), 32'd5);
    expect_seq("wr10", 1'b1, 8'h10, 32'hDEADBEEF);
    check("wr10_rdata_kept", rd, 32'h20020005);

    do_txn(1'b0, 8'h10, 32'h0, 0, rd, lat);
    check("rd10_data", rd, 32'hDEADBEEF);

    do_txn(1'b0, 8'h13, 32'h0, 0, rd, lat);
    check("rd13_data", rd, 32'hDEADBEEF);
    expect_seq("rd13", 1'b0, 8'h13, 32'h0);

    do_txn(1'b0, 8'h04, 32'h0, 3, rd, lat);
    check("bp_data", rd, 32'h20020005);
    check("bp_after_ready", {31'b0, req_ready}, 32'd1);
    check("bp_no_extra", q_mar.size(), 32'd4);

    // Reset while the third byte of a read is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h08;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_mar_cnt2", {24'b0, mar}, 32'h0A);
    reset_n = 1'b0;
    #1;
    check("mid_memread", {31'b0, memread}, 32'd0);
    check("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_halt", {31'b0, halt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_ready", {31'b0, req_ready}, 32'd1);
    do_txn(1'b0, 8'h04, 32'h0, 0, rd, lat);
    check("mid_reread", rd, 32'h20020005);

    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(16, 255));
      wd = $urandom;
      do_txn(wr, a, wd, 0, rd, lat);
      check("rnd_lat", 32'(lat), wr ? 32'd5 : 32'd6);
      expect_seq("rnd", wr, a, wd);
      if (wr) {ref_mem[{a[7:2], 2'b11}], ref_mem[{a[7:2], 2'b10}],
               ref_mem[{a[7:2], 2'b01}], ref_mem[{a[7:2], 2'b00}]} = wd;
      else    check("rnd_data", rd, ref_word(a));
    end

    @(negedge clk);
    kraj = 1'b1;
    do_txn(1'b0, 8'h08, 32'h0, 0, rd, lat);
    kraj = 1'b0;
    check("halt_rd_data", rd, 32'hFF000000);
`ifdef MEMSEQ_HALT_EN
    check("halt_set", {31'b0, halt}, 32'd1);
    q_mar.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h04;
      @(posedge clk); #1;
      check("halt_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    check("halt_no_access", q_mar.size(), 32'd0);
    check("halt_sticky", {31'b0, halt}, 32'd1);
`else
    check("nohalt_flag", {31'b0, halt}, 32'd0);
    do_txn(1'b0, 8'h04, 32'h0, 0, rd, lat);
    check("nohalt_next", rd, 32'h20020005);
    check("nohalt_lat", 32'(lat), 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
